// File: rtl/ram_stream_reader.sv
// Streams a (base, length) window of a 1-cycle-latency RAM onto a valid/ready
// output, with address wrap at DEPTH, a 3-entry skid FIFO and a last-word tag.
module ram_stream_reader #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 2048,
  parameter int ADDR_BITS = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_BITS-1:0] cmd_base,
  input  logic [ADDR_BITS:0]   cmd_len,
  output logic                 rd_en,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic [WIDTH-1:0]     rd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);
  localparam logic [ADDR_BITS:0]   REM_ONE   = (ADDR_BITS+1)'(1);

  // state | meaning
  // IDLE  | waiting for a command
  // RUN   | issuing reads while FIFO + in-flight credit allows
  // DRAIN | all reads issued, waiting for the FIFO to empty
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state, state_next;
  logic                 armed;
  logic [ADDR_BITS-1:0] addr_cnt;
  logic [ADDR_BITS:0]   remaining;
  logic                 inflight, inflight_last;
  logic [WIDTH-1:0]     fifo_data [3];
  logic [2:0]           fifo_last;
  logic [1:0]           wr_ptr, rd_ptr, fifo_count;
  logic                 accept, issue, push, pop, drained;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit uses only registered counts, so out_ready never reaches rd_en.
  assign issue     = (state == RUN) && (({1'b0, fifo_count} + {2'b00, inflight}) < 3'd3);
  assign cmd_ready = (state == IDLE) && armed;
  assign accept    = cmd_valid && cmd_ready;
  assign push      = inflight;
  assign pop       = out_valid && out_ready;
  assign drained   = (fifo_count == 2'd0) && !inflight;

  assign rd_en     = issue;
  assign rd_addr   = addr_cnt;
  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_last  = out_valid && fifo_last[rd_ptr];
  assign busy      = (state != IDLE);

  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = (cmd_len == '0) ? DRAIN : RUN;
      end
      RUN: begin
        if (issue && remaining == REM_ONE) state_next = DRAIN;
      end
      DRAIN: begin
        if (drained) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      armed         <= 1'b0;
      addr_cnt      <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      fifo_last     <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
    end else begin
      state         <= state_next;
      armed         <= 1'b1;
      inflight      <= issue;
      inflight_last <= issue && (remaining == REM_ONE);
      if (accept) begin
        addr_cnt  <= cmd_base;
        remaining <= cmd_len;
      end else if (issue) begin
        addr_cnt  <= (addr_cnt == LAST_ADDR) ? '0 : addr_cnt + 1'b1;
        remaining <= remaining - REM_ONE;
      end
      if (push) begin
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      fifo_count <= fifo_count + 2'd1;
      else if (!push && pop) fifo_count <= fifo_count - 2'd1;
    end
  end

  // Payload needs no reset: out_data is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_data[wr_ptr] <= rd_data;
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench: RAM model plus a transaction-level reference of the
// expected address/data stream, credit limit, stall stability and timing.
module tb_ram_stream_reader;
  localparam int WIDTH = 8, DEPTH = 2048, ADDR_BITS = 11;

  logic clk = 1'b0, rst = 1'b0, cmd_valid = 1'b0, out_ready = 1'b0;
  logic [ADDR_BITS-1:0] cmd_base = '0;
  logic [ADDR_BITS:0]   cmd_len = '0;
  logic cmd_ready, rd_en, out_valid, out_last, busy, done;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [WIDTH-1:0] rd_data, out_data;
  logic [WIDTH-1:0] mem [DEPTH];
  int checks = 0, errors = 0;
  bit after_done = 1'b0, chained = 1'b0;

  ram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // mode: 0 = out_ready high, 1 = random, 2 = pattern 1,0,0 repeating.
  // exact: check cycle-accurate timing (only meaningful with mode 0).
  task automatic run_cmd(input int base, input int len, input int mode, input bit exact,
                         input bit chain, input int nbase, input int nlen, input int abort_at);
    int issued = 0, popped = 0, n = 0, budget;
    bit hold = 1'b0, finished = 1'b0;
    logic [WIDTH-1:0] held_data = '0;
    logic held_last = 1'b0;
    budget = 4 * len + 40;
    @(negedge clk);
    #1;
    if (after_done) begin
      chk("idle_busy", busy, 0);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_cmd_ready", cmd_ready, 1);
    end
    if (chained) chk("b2b_accept_next_cycle", cmd_ready, 1);
    after_done = 1'b0;
    chained = 1'b0;
    cmd_valid = 1'b1;
    cmd_base = base[ADDR_BITS-1:0];
    cmd_len = len[ADDR_BITS:0];
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
    for (int k = 1; k <= budget && !finished; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 1'b0;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (k % 3 == 1);
      endcase
      #1;
      chk("busy", busy, 1);
      chk("cmd_ready_busy", cmd_ready, 0);
      chk("rd_en_credit", rd_en, (issued < len) && (issued - popped < 3));
      if (rd_en) begin
        chk("rd_addr", rd_addr, (base + issued) % DEPTH);
        issued++;
      end
      if (exact) chk("out_valid_timing", out_valid, (k >= 3 && k <= len + 2));
      if (hold) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, held_data);
        chk("stall_last", out_last, held_last);
      end
      hold = out_valid && !out_ready;
      held_data = out_data;
      held_last = out_last;
      if (out_valid && out_ready) begin
        chk("no_extra_word", popped < len, 1);
        chk("out_data", out_data, mem[(base + popped) % DEPTH]);
        chk("out_last", out_last, popped == len - 1);
        popped++;
      end
      if (k == abort_at) begin
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk_reset_outputs("midrst");
        rst = 1'b1;
        for (int j = 0; j < 6; j++) begin
          @(negedge clk);
          #1;
          if (j == 0) chk("post_rst_cmd_ready", cmd_ready, 1);
          chk("post_rst_out_valid", out_valid, 0);
          chk("post_rst_rd_en", rd_en, 0);
        end
        finished = 1'b1;
      end else if (done) begin
        chk("done_words", popped, len);
        chk("done_issued", issued, len);
        if (exact) chk("done_cycle", k, (len == 0) ? 1 : len + 3);
        finished = 1'b1;
        after_done = 1'b1;
        if (chain) begin
          cmd_valid = 1'b1;
          cmd_base = nbase[ADDR_BITS-1:0];
          cmd_len = nlen[ADDR_BITS:0];
          chained = 1'b1;
        end
      end
    end
    if (!finished) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int base, len, mode;
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'(a);
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("ready_after_release", cmd_ready, 1);

    run_cmd(10, 4, 0, 1, 0, 0, 0, -1);
    run_cmd(2046, 4, 0, 1, 0, 0, 0, -1);
    run_cmd(100, 8, 2, 0, 0, 0, 0, -1);
    run_cmd(5, 0, 0, 1, 0, 0, 0, -1);
    run_cmd(20, 6, 0, 1, 0, 0, 0, 4);
    run_cmd(0, 2, 0, 1, 0, 0, 0, -1);
    run_cmd(30, 3, 0, 1, 1, 40, 2, -1);
    run_cmd(40, 2, 0, 1, 0, 0, 0, -1);

    for (int a = 0; a < DEPTH; a++) mem[a] = 8'($urandom);
    for (int t = 0; t < 10; t++) begin
      base = int'($urandom_range(0, DEPTH - 1));
      len = int'($urandom_range(0, 24));
      mode = int'($urandom_range(0, 2));
      run_cmd(base, len, mode, mode == 0, 0, 0, 0, -1);
    end
    run_cmd(2000, 2100, 1, 0, 0, 0, 0, -1);
    run_cmd(1, 2049, 0, 1, 0, 0, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
